// File: rtl/layer_scan_ctl.sv
// Refresh scheduler for the LED cube layer RAMs: swaps the display bank on each finished host frame,
// streams every pixel address to the WS2812 encoders, then holds the latch gap.
module layer_scan_ctl #(
  parameter int unsigned PIXELS     = 64,
  parameter int unsigned RST_CYCLES = 24000
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      wr_done_in,
  output logic                      bank_sel_out,
  output logic                      rd_en_out,
  output logic [$clog2(PIXELS)-1:0] rd_addr_out,
  input  logic [191:0]              rd_data_in,
  output logic                      pix_vld_out,
  input  logic                      pix_rdy_in,
  output logic [191:0]              pix_data_out,
  output logic                      busy_out,
  output logic                      scan_done_out
);

  localparam int unsigned AddrW = $clog2(PIXELS);
  localparam int unsigned CntW  = $clog2(RST_CYCLES + 1);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(PIXELS - 1);
  localparam logic [CntW-1:0]  CntLoad  = CntW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StPresent,
    StLatch
  } state_e;

  state_e             state_q, state_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               bank_q, bank_d;
  logic               pending_q, pending_d;
  logic               vld_q, vld_d;
  logic [191:0]       data_q, data_d;
  logic               start;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      cnt_q     <= '0;
      bank_q    <= 1'b0;
      pending_q <= 1'b0;
      vld_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      bank_q    <= bank_d;
      pending_q <= pending_d;
      vld_q     <= vld_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    bank_d        = bank_q;
    vld_d         = vld_q;
    data_d        = data_q;
    rd_en_out     = 1'b0;
    scan_done_out = 1'b0;

    // Frames finishing while busy coalesce into one deferred scan.
    start     = (state_q == StIdle) && (pending_q || wr_done_in);
    pending_d = start ? 1'b0 : (pending_q || wr_done_in);

    unique case (state_q)
      StIdle: begin
        addr_d = '0;
        if (start) begin
          bank_d  = ~bank_q;
          state_d = StFetch;
        end
      end
      StFetch: begin
        rd_en_out = 1'b1;
        state_d   = StLoad;
      end
      StLoad: begin
        data_d  = rd_data_in;
        vld_d   = 1'b1;
        state_d = StPresent;
      end
      StPresent: begin
        if (pix_rdy_in) begin
          vld_d = 1'b0;
          if (addr_q == LastAddr) begin
            cnt_d   = CntLoad;
            state_d = StLatch;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StLatch: begin
        if (cnt_q == '0) begin
          scan_done_out = 1'b1;
          addr_d        = '0;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bank_sel_out = bank_q;
  assign rd_addr_out  = addr_q;
  assign pix_vld_out  = vld_q;
  assign pix_data_out = data_q;
  assign busy_out     = (state_q != StIdle);

endmodule

// File: tb/tb_layer_scan_ctl.sv
// Directed bench for layer_scan_ctl: a per-cycle vector table for the first pixels, then whole-scan
// sequences for stalls, coalesced frames, start coincidence and mid-scan reset.
module tb_layer_scan_ctl;

  localparam int P = 64;
  localparam int R = 100;
  localparam int ScanLen = 3 * P + R;  // start cycle to scan_done_out cycle at full rate

  logic         clk_in = 1'b0;
  logic         rst_n_in = 1'b0;
  logic         wr_done_in = 1'b0;
  logic         bank_sel_out;
  logic         rd_en_out;
  logic [5:0]   rd_addr_out;
  logic [191:0] rd_data_in = '0;
  logic         pix_vld_out;
  logic         pix_rdy_in = 1'b0;
  logic [191:0] pix_data_out;
  logic         busy_out;
  logic         scan_done_out;

  layer_scan_ctl #(.PIXELS(P), .RST_CYCLES(R)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .wr_done_in    (wr_done_in),
    .bank_sel_out  (bank_sel_out),
    .rd_en_out     (rd_en_out),
    .rd_addr_out   (rd_addr_out),
    .rd_data_in    (rd_data_in),
    .pix_vld_out   (pix_vld_out),
    .pix_rdy_in    (pix_rdy_in),
    .pix_data_out  (pix_data_out),
    .busy_out      (busy_out),
    .scan_done_out (scan_done_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [191:0] pat(input int a);
    logic [191:0] p;
    for (int n = 0; n < 8; n++) p[24*n +: 24] = {8'(n), 16'(a)};
    return p;
  endfunction

  // Layer RAM model: one-cycle read latency.
  always @(posedge clk_in) if (rd_en_out) rd_data_in <= pat(int'(rd_addr_out));

  int n_vec = 0;
  int n_miss = 0;
  int n_rd, n_hs, errs, stall_err, stall_n, done_at;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [202:0] all_outs();
    return {bank_sel_out, rd_en_out, rd_addr_out, pix_vld_out, busy_out, scan_done_out,
            pix_data_out};
  endfunction

  // Caller sits in the start cycle; runs until scan_done_out or the cycle budget expires.
  task automatic scan(input int stall_addr, input bit pulses);
    int cyc, exp_addr;
    logic bank0;
    logic [191:0] snap;
    cyc = 0; exp_addr = 0; bank0 = bank_sel_out; snap = '0;
    n_rd = 0; n_hs = 0; errs = 0; stall_err = 0; stall_n = 0; done_at = -1;
    while (cyc < ScanLen + 100) begin
      step();
      cyc++;
      wr_done_in = pulses && (cyc == 40 || cyc == 90 || cyc == 3 * P + 20);
      if (bank_sel_out !== ~bank0) errs++;
      if (rd_addr_out > 6'(P - 1)) errs++;
      if (rd_en_out) begin
        if (int'(rd_addr_out) != exp_addr) errs++;
        exp_addr++;
        n_rd++;
      end
      pix_rdy_in = 1'b1;
      if (stall_n > 0 && stall_n < 10) begin
        if (!pix_vld_out || int'(rd_addr_out) != stall_addr || pix_data_out !== snap || rd_en_out)
          stall_err++;
        pix_rdy_in = 1'b0;
        stall_n++;
      end else if (stall_n == 0 && pix_vld_out && int'(rd_addr_out) == stall_addr) begin
        snap = pix_data_out;
        pix_rdy_in = 1'b0;
        stall_n = 1;
      end
      if (pix_vld_out && pix_rdy_in) begin
        if (pix_data_out !== pat(n_hs)) errs++;
        n_hs++;
      end
      if (scan_done_out) begin
        done_at = cyc;
        break;
      end
    end
    wr_done_in = 1'b0;
  endtask

  task automatic post_scan(input string tag, input int exp_done, input logic exp_bank);
    check({tag, "_rd_en_cnt"}, n_rd, P);
    check({tag, "_handshakes"}, n_hs, P);
    check({tag, "_seq_errs"}, errs, 0);
    check({tag, "_done_cycle"}, done_at, exp_done);
    step();
    check({tag, "_after"}, {busy_out, scan_done_out, bank_sel_out}, {2'b00, exp_bank});
  endtask

  task automatic idle_check(input string name);
    logic seen;
    seen = 1'b0;
    repeat (6) begin
      step();
      seen |= busy_out;
    end
    check(name, seen, 1'b0);
  endtask

  typedef struct {
    logic       wr;
    logic       rdy;
    logic       bank;
    logic       rd_en;
    logic [5:0] addr;
    logic       vld;
    logic       busy;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic hit;
    logic seen;
    // inputs for the cycle, then outputs expected after the next edge
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0};  // idle, nothing pending
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b1};  // start -> fetch 0, bank flips
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1};  // rdy ignored in fetch
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1};  // present pixel 0
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1};  // held, no ready
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd1, 1'b0, 1'b1};  // handshake -> fetch 1
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd1, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd2, 1'b0, 1'b1};

    repeat (2) @(posedge clk_in);
    #1;
    check("reset_outputs", all_outs(), '0);
    rst_n_in = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      wr_done_in = tbl[i].wr;
      pix_rdy_in = tbl[i].rdy;
      step();
      check($sformatf("tbl%0d", i),
            {bank_sel_out, rd_en_out, rd_addr_out, pix_vld_out, busy_out, scan_done_out},
            {tbl[i].bank, tbl[i].rd_en, tbl[i].addr, tbl[i].vld, tbl[i].busy, 1'b0});
      if (tbl[i].vld) check($sformatf("tbl%0d_data", i), pix_data_out, pat(int'(tbl[i].addr)));
    end
    wr_done_in = 1'b0;

    rst_n_in = 1'b0;
    #1;
    check("rst_after_tbl", all_outs(), '0);
    step();
    rst_n_in = 1'b1;
    step();

    // Full-rate scan
    check("full_bank_before", bank_sel_out, 1'b0);
    wr_done_in = 1'b1;
    scan(-1, 1'b0);
    post_scan("full", ScanLen, 1'b1);

    // Ten-cycle stall at address 5
    wr_done_in = 1'b1;
    scan(5, 1'b0);
    check("stall_len", stall_n, 10);
    check("stall_stable", stall_err, 0);
    post_scan("stall", ScanLen + 10, 1'b0);

    // Three frames during a scan coalesce into one follow-on scan
    wr_done_in = 1'b1;
    scan(-1, 1'b1);
    post_scan("multi1", ScanLen, 1'b1);
    scan(-1, 1'b0);
    post_scan("multi2", ScanLen, 1'b0);
    idle_check("multi_single_extra");

    // New frame coinciding with a pending start
    wr_done_in = 1'b1;
    scan(-1, 1'b1);
    post_scan("coinc1", ScanLen, 1'b1);
    wr_done_in = 1'b1;
    scan(-1, 1'b0);
    post_scan("coinc2", ScanLen, 1'b0);
    idle_check("coinc_single");

    // Reset while presenting address 30
    pix_rdy_in = 1'b1;
    wr_done_in = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 400; c++) begin
      step();
      wr_done_in = 1'b0;
      if (pix_vld_out && rd_addr_out == 6'd30) begin
        pix_rdy_in = 1'b0;
        hit = 1'b1;
        break;
      end
    end
    check("reach_addr30", hit, 1'b1);
    rst_n_in = 1'b0;
    #1;
    check("midscan_rst_outs", all_outs(), '0);
    seen = 1'b0;
    repeat (3) begin
      step();
      seen |= scan_done_out | busy_out;
    end
    rst_n_in = 1'b1;
    pix_rdy_in = 1'b1;
    repeat (4) begin
      step();
      seen |= scan_done_out | busy_out;
    end
    check("no_done_after_rst", seen, 1'b0);
    check("rst_bank_zero", bank_sel_out, 1'b0);
    wr_done_in = 1'b1;
    scan(-1, 1'b0);
    post_scan("after_rst", ScanLen, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
